// File: rtl/dma_bram_mem.sv
// Block-RAM responder for the bsg_cache DMA interface, used in place of DDR3 during bring-up.
// Define DMA_BRAM_MEM_ADDR_CHECK_EN to flag out-of-range packet addresses on error_o.
module dma_bram_mem #(
    parameter int addr_width_p  = 28,
    parameter int data_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int mem_els_p     = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,
    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o,
    output logic                    busy_o,
    output logic                    error_o
);

    localparam int BEATS = block_width_p / data_width_p;
    localparam int BYTEW = $clog2(data_width_p / 8);
    localparam int IW    = $clog2(mem_els_p);
    localparam int OFFW  = $clog2(BEATS);
    localparam int CW    = (OFFW > 0) ? OFFW : 1;
    localparam logic [CW-1:0] LAST     = CW'(BEATS - 1);
    localparam logic [IW-1:0] OFF_MASK = IW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e            state_q;
    logic [IW-1:0]     base_q;
    logic [CW-1:0]     rcnt_q;
    logic [CW-1:0]     wcnt_q;
    logic              dv_q;
    logic [data_width_p-1:0] rdata_q;
    logic [data_width_p-1:0] mem [mem_els_p];

    logic [IW-1:0] pkt_base;
    logic          pkt_we;
    logic          rd_en;
    logic [CW-1:0] rd_off;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          unused_pkt;

    assign pkt_we     = dma_pkt_i[addr_width_p];
    assign pkt_base   = dma_pkt_i[BYTEW +: IW] & ~OFF_MASK;
    assign unused_pkt = ^dma_pkt_i;

    assign dma_pkt_yumi_o  = (state_q == IDLE) & dma_pkt_v_i & ~reset_i;
    assign dma_data_yumi_o = (state_q == WRITE) & dma_data_v_i & ~reset_i;
    assign dma_data_v_o    = dv_q;
    assign dma_data_o      = rdata_q;
    assign busy_o          = (state_q != IDLE);

    // First READ cycle issues beat 0; afterwards each handshake issues the next beat.
    assign rd_en  = (state_q == READ) &
                    (~dv_q | (dma_data_ready_and_i & (rcnt_q != LAST)));
    assign rd_off = dv_q ? rcnt_q + CW'(1) : '0;
    assign rd_idx = base_q + IW'(rd_off);
    assign wr_idx = base_q + IW'(wcnt_q);

    always_ff @(posedge clk_i) begin
        if (dma_data_yumi_o) mem[wr_idx] <= dma_data_i;
        if (rd_en) rdata_q <= mem[rd_idx];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dma_pkt_yumi_o) begin
                        base_q  <= pkt_base;
                        rcnt_q  <= '0;
                        wcnt_q  <= '0;
                        state_q <= pkt_we ? WRITE : READ;
                    end
                end
                READ: begin
                    if (!dv_q) begin
                        dv_q <= 1'b1;
                    end else if (dma_data_ready_and_i) begin
                        if (rcnt_q == LAST) begin
                            dv_q    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            rcnt_q <= rcnt_q + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (dma_data_v_i) begin
                        wcnt_q <= wcnt_q + CW'(1);
                        if (wcnt_q == LAST) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMA_BRAM_MEM_ADDR_CHECK_EN
    localparam logic [addr_width_p:0] ADDR_LIMIT =
        (addr_width_p + 1)'(mem_els_p * (data_width_p / 8));

    logic err_q;

    // Out-of-range packets are still serviced with the wrapped index.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (dma_pkt_yumi_o &&
                     ({1'b0, dma_pkt_i[addr_width_p-1:0]} >= ADDR_LIMIT)) begin
            err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
